// File: rtl/memory_stage_pkg.sv
// Shared types and slicing helpers for the multi-channel MEM stage.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package memory_stage_pkg;

    // Kind of access held in the response pipeline register. ACC_NONE marks an empty slot.
    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_ALU   = 2'd1,
        ACC_LOAD  = 2'd2,
        ACC_STORE = 2'd3
    } acc_kind_t;

    // Which requester owns the response currently in flight.
    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_CH  = 1'b1
    } src_t;

    // Width of an index over n items. This is never zero, so a single channel still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of item idx in a packed vector of w-bit items.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: picks one RAM user per cycle. The CPU has priority. Channels are served round-robin and
// can preempt the CPU once they have been denied for STARVE_MAX cycles in a row.
// Latency: the grant is combinational. Backpressure: denied requesters must hold their request.
// Ports: clk/rst | cpu_valid_i, ch_req_i in | cpu_ready_o, ch_gnt_o (one-hot), ch_win_o, ch_idx_o out
module rr_arbiter
    import memory_stage_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_valid_i,
    input  logic [N_CH-1:0]          ch_req_i,
    output logic                     cpu_ready_o,
    output logic [N_CH-1:0]          ch_gnt_o,
    output logic                     ch_win_o,
    output logic [idx_w(N_CH)-1:0]   ch_idx_o
);

    localparam int IDX_W = idx_w(N_CH);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             any_req;
    logic             starved;
    logic [IDX_W-1:0] win_idx;

    // Find the first requester at or after rr_ptr, wrapping around to channel 0.
    always_comb begin : pick
        int  cand;
        logic found;
        cand    = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= N_CH) cand = cand - N_CH;
            if (!found && ch_req_i[cand]) begin
                found   = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    assign any_req     = |ch_req_i;
    assign starved     = (starve_q == CNT_W'(STARVE_MAX));
    assign ch_win_o    = any_req && (starved || !cpu_valid_i);
    assign cpu_ready_o = cpu_valid_i && !ch_win_o;
    assign ch_idx_o    = win_idx;

    always_comb begin
        ch_gnt_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_gnt_o[i] = ch_win_o && (win_idx == IDX_W'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (ch_win_o) begin
            rr_ptr_d = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + IDX_W'(1);
        end
    end

    // Counts cycles in which some channel waited. A grant or an idle request bus clears it.
    // It stops at STARVE_MAX, because reaching STARVE_MAX forces a channel grant.
    always_comb begin
        starve_d = starve_q;
        if (ch_win_o || !any_req) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            starve_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/memory_stage_mc.sv
// Purpose: MEM stage in which one synchronous RAM is shared by the CPU load/store path and N_CH
// read-only streaming channels. There is one access per cycle.
// Latency: every accepted access responds exactly 1 cycle later. Backpressure: only through
// cpu_ready/ch_gnt (held requests); the outputs are never stalled.
// Ports: clk, rst | cpu_valid, cpu_ready, mem_to_reg, mem_write_en, address_a, alu_result, result,
//        wb_valid | ch_req, ch_addr, ch_gnt, ch_rvalid, ch_data | oob_err
module memory_stage_mc
    import memory_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 18,
    parameter int DEPTH      = 4096,
    parameter int PIX_W      = 24,
    parameter int N_CH       = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic                     mem_to_reg,
    input  logic                     mem_write_en,
    input  logic [ADDR_W-1:0]        address_a,
    input  logic [DATA_W-1:0]        alu_result,
    output logic [DATA_W-1:0]        result,
    output logic                     wb_valid,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    output logic [N_CH-1:0]          ch_gnt,
    output logic [N_CH-1:0]          ch_rvalid,
    output logic [N_CH*PIX_W-1:0]    ch_data,
    output logic                     oob_err
);

    localparam int IDX_W  = idx_w(N_CH);
    localparam int RAM_AW = idx_w(DEPTH);

    typedef struct packed {
        src_t              src;
        logic [IDX_W-1:0]  ch;
        acc_kind_t         kind;
        logic              oob;
        logic [DATA_W-1:0] alu;
    } pipe_t;

    logic              ch_win;
    logic [IDX_W-1:0]  ch_idx;
    logic [ADDR_W-1:0] acc_addr;
    logic              in_range;
    logic [RAM_AW-1:0] ram_idx;
    acc_kind_t         cpu_kind;
    logic              ram_we, ram_re;
    pipe_t             pipe_q, pipe_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] result_q;
    logic [N_CH*PIX_W-1:0] ch_data_q;

    rr_arbiter #(
        .N_CH       (N_CH),
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .cpu_valid_i (cpu_valid),
        .ch_req_i    (ch_req),
        .cpu_ready_o (cpu_ready),
        .ch_gnt_o    (ch_gnt),
        .ch_win_o    (ch_win),
        .ch_idx_o    (ch_idx)
    );

    assign acc_addr = cpu_ready ? address_a
                                : ch_addr[slice_lo(int'(ch_idx), ADDR_W) +: ADDR_W];
    assign in_range = 64'(acc_addr) < 64'(DEPTH);
    assign ram_idx  = acc_addr[RAM_AW-1:0];

    // If both mem_to_reg and mem_write_en are set, the op is treated as a store.
    always_comb begin
        if (mem_write_en)    cpu_kind = ACC_STORE;
        else if (mem_to_reg) cpu_kind = ACC_LOAD;
        else                 cpu_kind = ACC_ALU;
    end

    // A store and a read never share a cycle, so the RAM only needs one port.
    assign ram_we = cpu_ready && (cpu_kind == ACC_STORE) && in_range;
    assign ram_re = in_range && ((cpu_ready && cpu_kind == ACC_LOAD) || ch_win);

    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_idx] <= alu_result;
        if (ram_re) rdata_q <= mem_q[ram_idx];
    end

    always_comb begin
        pipe_d = '0;
        if (cpu_ready) begin
            pipe_d.src  = SRC_CPU;
            pipe_d.kind = cpu_kind;
            pipe_d.oob  = (cpu_kind != ACC_ALU) && !in_range;
            pipe_d.alu  = alu_result;
        end else if (ch_win) begin
            pipe_d.src  = SRC_CH;
            pipe_d.ch   = ch_idx;
            pipe_d.kind = ACC_LOAD;
            pipe_d.oob  = !in_range;
        end
    end

    // The responses are driven combinationally from the pipeline register and the RAM output register.
    // The _q copies keep the last values so that result and ch_data hold between pulses.
    always_comb begin
        wb_valid = (pipe_q.kind != ACC_NONE) && (pipe_q.src == SRC_CPU);
        result   = result_q;
        if (wb_valid) begin
            if (pipe_q.kind == ACC_LOAD) result = pipe_q.oob ? '0 : rdata_q;
            else                         result = pipe_q.alu;
        end
    end

    always_comb begin
        ch_rvalid = '0;
        ch_data   = ch_data_q;
        if ((pipe_q.kind != ACC_NONE) && (pipe_q.src == SRC_CH)) begin
            ch_rvalid[pipe_q.ch] = 1'b1;
            ch_data[slice_lo(int'(pipe_q.ch), PIX_W) +: PIX_W] =
                pipe_q.oob ? '0 : rdata_q[PIX_W-1:0];
        end
    end

    assign oob_err = (pipe_q.kind != ACC_NONE) && pipe_q.oob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q    <= '0;
            result_q  <= '0;
            ch_data_q <= '0;
        end else begin
            pipe_q    <= pipe_d;
            result_q  <= result;
            ch_data_q <= ch_data;
        end
    end

endmodule

// File: tb/tb_memory_stage_mc.sv
module tb_memory_stage_mc;

    localparam int DATA_W = 32, ADDR_W = 18, DEPTH = 4096, PIX_W = 24, N_CH = 2, STARVE_MAX = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cpu_valid, cpu_ready, mem_to_reg, mem_write_en;
    logic [ADDR_W-1:0]      address_a;
    logic [DATA_W-1:0]      alu_result, result;
    logic                   wb_valid, oob_err;
    logic [N_CH-1:0]        ch_req, ch_gnt, ch_rvalid;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*PIX_W-1:0]  ch_data;

    memory_stage_mc #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .PIX_W(PIX_W), .N_CH(N_CH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .mem_to_reg(mem_to_reg), .mem_write_en(mem_write_en), .address_a(address_a),
        .alu_result(alu_result), .result(result), .wb_valid(wb_valid),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid),
        .ch_data(ch_data), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    // Reference model: the RAM image plus the expected externally visible state.
    logic [DATA_W-1:0] ram_m [0:DEPTH-1];
    int                rr_m, starve_m;
    logic [DATA_W-1:0] res_m;
    logic              wb_m, oob_m;
    logic [N_CH-1:0]   rv_m, gnt_m;
    logic [PIX_W-1:0]  chd_m [N_CH];
    bit                cpu_win_m;
    logic [N_CH-1:0]   obs_gnt;
    logic              obs_rdy;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        res_m = '0; wb_m = 1'b0; oob_m = 1'b0; rv_m = '0; rr_m = 0; starve_m = 0;
        for (int i = 0; i < N_CH; i++) chd_m[i] = '0;
    endtask

    task automatic check_outputs();
        logic [N_CH*PIX_W-1:0] exp_chd;
        for (int i = 0; i < N_CH; i++) exp_chd[i*PIX_W +: PIX_W] = chd_m[i];
        chk("wb_valid", wb_valid, wb_m);
        chk("result", result, res_m);
        chk("ch_rvalid", ch_rvalid, rv_m);
        chk("ch_data", ch_data, exp_chd);
        chk("oob_err", oob_err, oob_m);
    endtask

    // One clock cycle. The inputs are already set. Check the grant decision, clock the edge,
    // advance the model, then check the response.
    task automatic step();
        bit any, chwin, found, inr;
        int w, idx;
        logic [ADDR_W-1:0] a;
        #1;
        any = (ch_req != '0);
        chwin = any && (starve_m == STARVE_MAX || !cpu_valid);
        w = 0; found = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (rr_m + k) % N_CH;
            if (!found && ch_req[idx]) begin found = 1; w = idx; end
        end
        cpu_win_m = cpu_valid && !chwin;
        gnt_m = chwin ? N_CH'(1 << w) : '0;
        obs_gnt = ch_gnt;
        obs_rdy = cpu_ready;
        chk("cpu_ready", cpu_ready, cpu_win_m);
        chk("ch_gnt", ch_gnt, gnt_m);
        @(posedge clk);
        #1;
        wb_m = cpu_win_m; rv_m = '0; oob_m = 1'b0;
        if (cpu_win_m) begin
            a = address_a; inr = (a < DEPTH);
            if (mem_write_en) begin
                if (inr) ram_m[a] = alu_result;
                res_m = alu_result; oob_m = !inr;
            end else if (mem_to_reg) begin
                res_m = inr ? ram_m[a] : '0; oob_m = !inr;
            end else begin
                res_m = alu_result;
            end
        end
        if (chwin) begin
            a = ch_addr[w*ADDR_W +: ADDR_W]; inr = (a < DEPTH);
            if (inr) begin
                logic [DATA_W-1:0] word;
                word = ram_m[a];
                chd_m[w] = word[PIX_W-1:0];
            end else begin
                chd_m[w] = '0;
            end
            rv_m = N_CH'(1 << w); oob_m = !inr;
            rr_m = (w + 1) % N_CH; starve_m = 0;
        end else begin
            starve_m = any ? ((starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX) : 0;
        end
        check_outputs();
    endtask

    task automatic cpu_op(input logic we, input logic ld, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        cpu_valid = 1'b1; mem_write_en = we; mem_to_reg = ld; address_a = a; alu_result = d;
    endtask

    task automatic cpu_idle();
        cpu_valid = 1'b0; mem_write_en = 1'b0; mem_to_reg = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 21);
        if (r < 16)       return ADDR_W'(r);
        else if (r == 16) return ADDR_W'(904);
        else if (r == 17) return ADDR_W'(4096);
        else if (r == 18) return ADDR_W'(4099);
        else if (r == 19) return ADDR_W'(5000);
        else if (r == 20) return '1;
        else              return ADDR_W'(7);
    endfunction

    initial begin
        int gnt_cycle;
        logic [N_CH-1:0] rr_seq [3];
        rst = 1'b1; ch_req = '0; ch_addr = '0; address_a = '0; alu_result = '0;
        cpu_idle();
        model_reset();
        #12;
        check_outputs();
        rst = 1'b0;

        // Fill every in-range address that later reads may touch.
        for (int a = 0; a < 16; a++) begin
            cpu_op(1, 0, ADDR_W'(a), $urandom); step();
        end
        cpu_op(1, 0, ADDR_W'(904), $urandom); step();

        // Store, then load the same word on the next cycle. Then a channel reads it.
        cpu_op(1, 0, 3, 32'h5555_5551); step();
        cpu_op(0, 1, 3, 32'h0); step();
        chk("load_after_store", result, 32'h5555_5551);
        cpu_idle(); ch_req = 2'b01; ch_addr[0 +: ADDR_W] = 3; step();
        chk("ch0_read", ch_data[PIX_W-1:0], 24'h55_5551);

        // The CPU is busy every cycle, so ch0 waits until the starvation guard fires.
        gnt_cycle = 0;
        cpu_op(0, 0, 9, 32'h1234); ch_req = 2'b01; ch_addr[0 +: ADDR_W] = 5;
        for (int c = 1; c <= 8; c++) begin
            if (gnt_cycle == 0) begin
                step();
                if (obs_gnt[0] === 1'b1) gnt_cycle = c;
            end
        end
        chk("starve_grant_cycle", gnt_cycle, 5);
        ch_req = '0;
        cpu_op(0, 0, 9, 32'h1235); step();
        chk("cpu_ready_after_starve", obs_rdy, 1'b1);

        // Out-of-range load and store. An aliasing store must not touch word 3.
        cpu_op(0, 1, 4096, 32'h0); step();
        chk("oob_load_result", result, 32'h0);
        chk("oob_load_flag", oob_err, 1'b1);
        cpu_op(1, 0, 5000, 32'hDEAD_BEEF); step();
        cpu_op(1, 0, 4099, 32'hCAFE_F00D); step();
        cpu_op(0, 1, 3, 32'h0); step();
        chk("alias_unchanged", result, 32'h5555_5551);
        cpu_op(0, 1, 904, 32'h0); step();

        // With both mem_to_reg and mem_write_en set, the op acts as a store.
        cpu_op(1, 1, 7, 32'hA5); step();
        chk("both_flags_result", result, 32'hA5);
        cpu_idle(); step();
        cpu_op(0, 1, 7, 32'h0); step();
        chk("both_flags_load", result, 32'hA5);

        // Reset while a load response is being presented.
        cpu_op(0, 1, 7, 32'h0); step();
        #2 rst = 1'b1;
        #1;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_ch_rvalid", ch_rvalid, 2'b00);
        chk("rst_oob", oob_err, 1'b0);
        chk("rst_result", result, 32'h0);
        cpu_idle();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // After reset, two channels request continuously and grants alternate.
        ch_req = 2'b11; ch_addr[0 +: ADDR_W] = 1; ch_addr[ADDR_W +: ADDR_W] = 2;
        for (int c = 0; c < 3; c++) begin
            step();
            rr_seq[c] = obs_gnt;
        end
        chk("rr_seq0", rr_seq[0], 2'b01);
        chk("rr_seq1", rr_seq[1], 2'b10);
        chk("rr_seq2", rr_seq[2], 2'b01);
        ch_req = '0;

        // Random traffic. Requesters hold their inputs until they are served.
        cpu_idle(); step();
        for (int n = 0; n < 3000; n++) begin
            if (!cpu_valid || cpu_win_m) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 3))
                        0: cpu_op(1, 0, rand_addr(), $urandom);
                        1: cpu_op(0, 1, rand_addr(), $urandom);
                        2: cpu_op(1, 1, rand_addr(), $urandom);
                        default: cpu_op(0, 0, rand_addr(), $urandom);
                    endcase
                end else begin
                    cpu_idle();
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                if (!ch_req[i] || gnt_m[i]) begin
                    ch_req[i] = ($urandom_range(0, 1) == 1);
                    ch_addr[i*ADDR_W +: ADDR_W] = rand_addr();
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
